// File: rtl/iterative_normalizer.sv
// Iterative normaliser: shifts a word left one bit per clock until its MSB
// (unsigned) or sign boundary (signed) is reached, reporting the shift count.
module iterative_normalizer #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_signed,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_shift,
  output logic          out_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [W-1:0]  r;
  logic [CW-1:0] count;
  logic          zero_q;
  logic          signed_q;
  logic          norm_done;
  logic          accept;

  // Signed words are normalised once the sign bit differs from the bit below it.
  assign norm_done = signed_q ? (r[W-1] ^ r[W-2]) : r[W-1];
  assign accept    = in_valid && (state == IDLE);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = r;
  assign out_shift = count;
  assign out_zero  = zero_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid) state_next = (in_data == '0) ? DONE : BUSY;
      BUSY: if (norm_done) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r        <= '0;
      count    <= '0;
      zero_q   <= 1'b0;
      signed_q <= 1'b0;
    end else if (accept) begin
      r        <= in_data;
      count    <= '0;
      zero_q   <= (in_data == '0);
      signed_q <= in_signed;
    end else if (state == BUSY && !norm_done) begin
      // A nonzero word terminates within W-1 shifts, so count cannot wrap.
      r     <= {r[W-2:0], 1'b0};
      count <= count + CW'(1);
    end
  end

endmodule
